// File: rtl/ysyx_25020047_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// the default instruction word substituted on faulted fetches.
package ysyx_25020047_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_HOLD
    } ifu_state_t;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit: one outstanding memory request at a time, with
// misalignment and timeout faults, flush/redirect handling and a holding slot toward the IDU.
module ysyx_25020047_ifu
    import ysyx_25020047_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INST       = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch_en,
    input  logic        flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fetch_err
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ifu_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;

    // The current silent cycle is the last one allowed; counter saturates at the limit.
    assign timeout_hit = (cnt >= CNT_LAST);
    assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= '0;
            inst           <= '0;
            inst_pc        <= '0;
            inst_valid     <= 1'b0;
            fetch_err      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!flush && fetch_en) begin
                        if (pc[1:0] == 2'b00) begin
                            imem_req_addr  <= pc;
                            imem_req_valid <= 1'b1;
                            state          <= S_REQ;
                        end else begin
                            inst       <= NOP_INST;
                            inst_pc    <= pc;
                            fetch_err  <= 1'b1;
                            inst_valid <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end
                end
                S_REQ: begin
                    // An accepted request must still be drained even when flushed.
                    if (flush) begin
                        imem_req_valid <= 1'b0;
                        cnt            <= '0;
                        state          <= imem_req_ready ? S_DRAIN : S_IDLE;
                    end else if (imem_req_ready) begin
                        imem_req_valid <= 1'b0;
                        cnt            <= '0;
                        state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        cnt   <= '0;
                        state <= imem_resp_valid ? S_IDLE : S_DRAIN;
                    end else if (imem_resp_valid) begin
                        inst       <= imem_resp_err ? NOP_INST : imem_resp_data;
                        inst_pc    <= imem_req_addr;
                        fetch_err  <= imem_resp_err;
                        inst_valid <= 1'b1;
                        state      <= S_HOLD;
                    end else begin
                        cnt <= cnt_inc;
                        if (timeout_hit) begin
                            inst       <= NOP_INST;
                            inst_pc    <= imem_req_addr;
                            fetch_err  <= 1'b1;
                            inst_valid <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end
                end
                S_DRAIN: begin
                    cnt <= cnt_inc;
                    if (imem_resp_valid || timeout_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (flush || inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
